// File: rtl/icdf_pkg.sv
// -----------------------------------------------------------------------------
// icdf_pkg
// Shared widths, types and helpers for the ICDF Gaussian generator front end.
//   U_W      : uniform word width (fixed by the segment scheme)
//   C_W      : polynomial coefficient width
//   M_W      : masked data width handed to the multiply-add stage
//   A_W      : coefficient table address width
//   SEG_N    : number of segments (leading-zero counts 0..16)
//   SUB_BITS : sub-segment bits taken from u[14:12]
// -----------------------------------------------------------------------------
package icdf_pkg;

    localparam int U_W       = 32;
    localparam int C_W       = 18;
    localparam int M_W       = 15;
    localparam int A_W       = 8;
    localparam int SEG_N     = 17;
    localparam int SUB_BITS  = 3;
    localparam int SEG_W     = $clog2(SEG_N);
    localparam int TBL_DEPTH = 1 << A_W;

    typedef struct packed {
        logic [C_W-1:0] coef2;
        logic [C_W-1:0] coef1;
    } coef_pair_t;

    // seg*8 + sub; seg never exceeds 16, so the concatenation fits in A_W bits.
    function automatic logic [A_W-1:0] seg_addr(input logic [SEG_W-1:0]    seg,
                                                 input logic [SUB_BITS-1:0] sub);
        return {seg, sub};
    endfunction

endpackage

// File: rtl/lzd16.sv
// -----------------------------------------------------------------------------
// lzd16
// Combinational 16-bit leading-zero counter.
//   din_i : 16-bit field to examine (MSB first)
//   cnt_o : number of leading zeros, 0..16 (16 when din_i is all zero)
// -----------------------------------------------------------------------------
module lzd16
    import icdf_pkg::*;
(
    input  logic [15:0]      din_i,
    output logic [SEG_W-1:0] cnt_o
);

    // Scan from LSB to MSB; the last hit is the most significant set bit.
    always_comb begin
        cnt_o = SEG_W'(16);
        for (int i = 0; i < 16; i++) begin
            if (din_i[i]) begin
                cnt_o = SEG_W'(15 - i);
            end
        end
    end

endmodule

// File: rtl/icdf_coef_fetch.sv
// -----------------------------------------------------------------------------
// icdf_coef_fetch
// Front end of the ICDF Gaussian datapath: splits a uniform word into sign,
// segment (leading zeros of u[30:15]), sub-segment (u[14:12]) and masked data,
// reads the coefficient pair for address seg*8+sub from a loadable 256x36
// table, and presents it to the 18x18 multiply-add stage.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : uniform word handshake, u is the word
//   tbl_we/addr/wdata     : table write port, wdata = {coef2, coef1}
//   out_valid / out_ready : coefficient set handshake
//   en_ma18               : multiply-add enable (out_valid & out_ready)
//   coef1, coef2          : coefficient pair read from the table
//   masked_out, sign_out  : u[14:0] and u[31] of the word
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds its data stable while valid=1 and ready=0.
// The whole pipeline advances together (adv = ~out_valid | out_ready), and
// in_ready is exactly adv, so ready never depends on in_valid.
// -----------------------------------------------------------------------------
module icdf_coef_fetch
    import icdf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [U_W-1:0]   u,
    input  logic             tbl_we,
    input  logic [A_W-1:0]   tbl_addr,
    input  logic [2*C_W-1:0] tbl_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             en_ma18,
    output logic [C_W-1:0]   coef1,
    output logic [C_W-1:0]   coef2,
    output logic [M_W-1:0]   masked_out,
    output logic             sign_out
);

    logic adv;

    // Stage 1: raw word
    logic [U_W-1:0]   s1_u_q;
    logic             s1_v_q;
    // Stage 2: table address and side data
    logic [A_W-1:0]   s2_addr_q;
    logic [A_W-1:0]   s2_addr_d;
    logic [M_W-1:0]   s2_mask_q;
    logic             s2_sign_q;
    logic             s2_v_q;
    // Stage 3: RAM read data (doubles as the output register)
    coef_pair_t       s3_coef_q;
    logic [M_W-1:0]   s3_mask_q;
    logic             s3_sign_q;
    logic             s3_v_q;

    logic [SEG_W-1:0] seg;

    coef_pair_t       mem_q [TBL_DEPTH];

    assign adv = ~s3_v_q | out_ready;

    lzd16 u_lzd16 (
        .din_i (s1_u_q[30:15]),
        .cnt_o (seg)
    );

    assign s2_addr_d = seg_addr(seg, s1_u_q[14:12]);

    // Table storage: not reset, written any cycle regardless of the pipeline.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            mem_q[tbl_addr] <= coef_pair_t'(tbl_wdata);
        end
    end

    // Pipeline registers. The stage 3 read samples mem_q before this edge's
    // write lands, which gives read-first behaviour on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_u_q    <= '0;
            s1_v_q    <= 1'b0;
            s2_addr_q <= '0;
            s2_mask_q <= '0;
            s2_sign_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_coef_q <= '0;
            s3_mask_q <= '0;
            s3_sign_q <= 1'b0;
            s3_v_q    <= 1'b0;
        end else if (adv) begin
            s1_u_q    <= u;
            s1_v_q    <= in_valid;
            s2_addr_q <= s2_addr_d;
            s2_mask_q <= s1_u_q[M_W-1:0];
            s2_sign_q <= s1_u_q[U_W-1];
            s2_v_q    <= s1_v_q;
            s3_coef_q <= mem_q[s2_addr_q];
            s3_mask_q <= s2_mask_q;
            s3_sign_q <= s2_sign_q;
            s3_v_q    <= s2_v_q;
        end
    end

    assign in_ready   = adv;
    assign out_valid  = s3_v_q;
    assign en_ma18    = s3_v_q & out_ready;
    assign coef1      = s3_coef_q.coef1;
    assign coef2      = s3_coef_q.coef2;
    assign masked_out = s3_mask_q;
    assign sign_out   = s3_sign_q;

endmodule

// File: tb/tb_icdf_coef_fetch.sv
`timescale 1ns/1ps
module tb_icdf_coef_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] u = '0;
    logic        tbl_we = 1'b0;
    logic [7:0]  tbl_addr = '0;
    logic [35:0] tbl_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        en_ma18;
    logic [17:0] coef1;
    logic [17:0] coef2;
    logic [14:0] masked_out;
    logic        sign_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference table ({coef2, coef1}) and expected outputs {sign, masked, coef2, coef1}
    logic [35:0] model_tbl [256];
    logic [51:0] exp_q[$];

    icdf_coef_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .u          (u),
        .tbl_we     (tbl_we),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .en_ma18    (en_ma18),
        .coef1      (coef1),
        .coef2      (coef2),
        .masked_out (masked_out),
        .sign_out   (sign_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [51:0] ref_word(input logic [31:0] w);
        int          seg;
        int          a;
        logic [15:0] f;
        f   = w[30:15];
        seg = 16;
        while (f != 0) begin
            f = f >> 1;
            seg--;
        end
        a = seg * 8 + int'(w[14:12]);
        return {w[31], w[14:0], model_tbl[a]};
    endfunction

    function automatic logic [31:0] gen_word();
        logic [15:0] f;
        f = 16'($urandom());
        f = f >> $urandom_range(0, 16);
        return {1'($urandom()), f, 15'($urandom())};
    endfunction

    function automatic logic [51:0] observed();
        return {sign_out, masked_out, coef2, coef1};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input int a, input logic [35:0] d);
        tbl_we    = 1'b1;
        tbl_addr  = 8'(a);
        tbl_wdata = d;
        step();
        tbl_we    = 1'b0;
        model_tbl[a] = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        #12;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_checks++;
        if (en_ma18 !== 1'b0) $display("FAIL reset_en_ma18: got %b want 0", en_ma18);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        n_checks++;
        if (observed() !== 52'h0) $display("FAIL reset_outputs: got %h want 0", observed());
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_table();
        for (int a = 0; a < 136; a++) begin
            load_entry(a, {18'($urandom()), 10'($urandom()), 8'(a)});
        end
        load_entry(5, {18'h00003, 18'h00001});
    endtask

    // One isolated word: output must appear after exactly the third edge.
    task automatic test_single(input string name, input logic [31:0] w);
        logic [51:0] exp;
        exp      = ref_word(w);
        out_ready = 1'b1;
        in_valid = 1'b1;
        u        = w;
        step();
        in_valid = 1'b0;
        u        = $urandom();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'(k == 3))
                $display("FAIL %s out_valid_edge%0d: got %b want %b", name, k, out_valid, k == 3);
            else n_pass++;
            n_checks++;
            if (en_ma18 !== 1'(k == 3))
                $display("FAIL %s en_ma18_edge%0d: got %b want %b", name, k, en_ma18, k == 3);
            else n_pass++;
            if (k == 3) begin
                n_checks++;
                if (observed() !== exp)
                    $display("FAIL %s data: got %h want %h", name, observed(), exp);
                else n_pass++;
            end
            step();
        end
    endtask

    // Streaming scenario: driver and sink run concurrently.
    task automatic test_stream(input string name, input int n, input bit gaps,
                               input int stall_at, input int stall_len, input bit rand_ready);
        int drain_bad;
        exp_q.delete();
        fork
            begin : driver
                logic [31:0] w;
                int waits;
                for (int i = 0; i < n; i++) begin
                    w        = gen_word();
                    in_valid = 1'b1;
                    u        = w;
                    waits    = 0;
                    do begin
                        @(negedge clk);
                        waits++;
                    end while (!in_ready && waits < 1000);
                    if (!in_ready) begin
                        n_checks++;
                        $display("FAIL %s accept_timeout: got in_ready=0 want 1", name);
                        in_valid = 1'b0;
                        break;
                    end
                    exp_q.push_back(ref_word(w));
                    step();
                    in_valid = 1'b0;
                    if (gaps) repeat ($urandom_range(0, 2)) step();
                end
            end
            begin : sink
                int got;
                int cyc;
                int last_pop;
                bit held;
                logic [51:0] snap;
                logic [51:0] obs;
                logic [51:0] exp;
                got = 0; cyc = 0; last_pop = -1; held = 1'b0; snap = '0;
                while (got < n && cyc < 3000) begin
                    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
                    else out_ready = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
                    @(negedge clk);
                    obs = observed();
                    if (held) begin
                        n_checks++;
                        if (out_valid !== 1'b1 || obs !== snap)
                            $display("FAIL %s hold: got v=%b %h want v=1 %h", name, out_valid, obs, snap);
                        else n_pass++;
                    end
                    held = 1'b0;
                    if (out_valid && !out_ready) begin
                        n_checks++;
                        if (in_ready !== 1'b0 || en_ma18 !== 1'b0)
                            $display("FAIL %s stall_ready: got in_ready=%b en=%b want 0 0", name, in_ready, en_ma18);
                        else n_pass++;
                        snap = obs;
                        held = 1'b1;
                    end
                    if (out_valid && out_ready) begin
                        n_checks++;
                        if (en_ma18 !== 1'b1) $display("FAIL %s en_ma18: got %b want 1", name, en_ma18);
                        else n_pass++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            $display("FAIL %s extra_output: got %h want none", name, obs);
                        end else begin
                            exp = exp_q.pop_front();
                            if (obs !== exp) $display("FAIL %s data%0d: got %h want %h", name, got, obs, exp);
                            else n_pass++;
                        end
                        if (!gaps && !rand_ready && stall_at == 0 && last_pop >= 0) begin
                            n_checks++;
                            if (cyc != last_pop + 1)
                                $display("FAIL %s throughput: got gap %0d want 1", name, cyc - last_pop);
                            else n_pass++;
                        end
                        last_pop = cyc;
                        got++;
                    end
                    cyc++;
                    step();
                end
                n_checks++;
                if (got != n) $display("FAIL %s count: got %0d want %0d", name, got, n);
                else n_pass++;
            end
        join
        out_ready = 1'b1;
        drain_bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) drain_bad++;
            step();
        end
        n_checks++;
        if (drain_bad != 0 || exp_q.size() != 0)
            $display("FAIL %s drain: got %0d late outputs, %0d pending want 0 0", name, drain_bad, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        test_stream("back_to_back", 8, 1'b0, 5, 4, 1'b0);
    endtask

    task automatic test_throughput();
        test_stream("throughput", 8, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_random_stream();
        test_stream("random", 60, 1'b1, 0, 0, 1'b1);
    endtask

    // Entry 5 written on the same edge its read is issued: old data out,
    // the following address-5 word sees the new data.
    task automatic test_read_first();
        logic [35:0] old_v;
        logic [35:0] new_v;
        old_v     = model_tbl[5];
        new_v     = {18'($urandom()), 18'($urandom())};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        u         = 32'h4000_5000;
        step();
        u         = 32'h4000_5ABC;
        step();
        in_valid  = 1'b0;
        tbl_we    = 1'b1;
        tbl_addr  = 8'd5;
        tbl_wdata = new_v;
        step();
        tbl_we    = 1'b0;
        model_tbl[5] = new_v;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || observed() !== {1'b0, 15'h5000, old_v})
            $display("FAIL read_first_old: got v=%b %h want v=1 %h", out_valid, observed(), {1'b0, 15'h5000, old_v});
        else n_pass++;
        step();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || observed() !== {1'b0, 15'h5ABC, new_v})
            $display("FAIL read_first_new: got v=%b %h want v=1 %h", out_valid, observed(), {1'b0, 15'h5ABC, new_v});
        else n_pass++;
        repeat (3) step();
    endtask

    task automatic test_reset_midstream();
        int late;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            u        = gen_word();
            step();
        end
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || en_ma18 !== 1'b0 || in_ready !== 1'b1 || observed() !== 52'h0)
            $display("FAIL midreset_immediate: got v=%b en=%b rdy=%b %h want 0 0 1 0",
                     out_valid, en_ma18, in_ready, observed());
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        late = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) late++;
            step();
        end
        n_checks++;
        if (late != 0) $display("FAIL midreset_flush: got %0d outputs want 0", late);
        else n_pass++;
        test_single("after_reset_e5", 32'h4000_5000);
        test_single("after_reset_e135", 32'h8000_7FFF);
    endtask

    initial begin
        test_reset();
        test_load_table();
        test_single("entry5", 32'h4000_5000);
        test_single("entry135", 32'h8000_7FFF);
        test_single("seg16_addr128", 32'h0000_0000);
        test_single("seg14_addr112", 32'h0001_0000);
        test_single("seg15_addr120", 32'h0000_8000);
        test_single("seg0_addr7", 32'hFFFF_FFFF);
        test_back_to_back();
        test_throughput();
        test_random_stream();
        test_read_first();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
